// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_ADDR = 3'd1;
  localparam logic [2:0] ERR_BAD_LEN  = 3'd2;
  localparam logic [2:0] ERR_BAD_CHK  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ERR_OVERRUN  = 3'd5;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte input from the UART receiver, register-file write port and frame status.
// Latency: n/a (wires only).
// Backpressure: none; the receiver level is sampled every cycle, writes cannot stall.
interface uart_cmd_ctrl_if;
  logic       rx_received;
  logic [7:0] rx_data;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       frame_ok;
  logic       frame_err;
  logic [2:0] err_code;

  // Byte source / register-file side
  modport master (
    output rx_received, rx_data,
    input  wr_en, wr_addr, wr_data, busy, frame_ok, frame_err, err_code
  );

  // Command controller side
  modport slave (
    input  rx_received, rx_data,
    output wr_en, wr_addr, wr_data, busy, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/uart_cmd_buf.sv
// Payload buffer: DEPTH x 8 registers, one synchronous write port, one combinational read port.
// Latency: write visible on read port the cycle after wr_en; read is same-cycle.
// Backpressure: none; a write is accepted every cycle wr_en is high.
module uart_cmd_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [7:0]    wr_dat,
  input  logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_dat
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  // Next-state of the storage: hold, or overwrite the addressed entry
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_dat;
    end
  end

  // Storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/ADDR/LEN/payload/CHK frames from a UART byte stream and commits them to a register file.
// Latency: first write the cycle after COMMIT entry (2 cycles after the CHK strobe); frame_ok 1 cycle after last write.
// Backpressure: none possible; bytes arriving during COMMIT are dropped and flagged as overrun.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int MAX_LEN        = 8
) (
  input logic           clk,
  input logic           rst_n,
  uart_cmd_ctrl_if.slave bus
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state_q, state_d;
  logic          rx_prev_q, rx_prev_d;
  logic [3:0]    base_q, base_d;
  logic [IW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_en_q, wr_en_d;
  logic [3:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [2:0]    err_code_q, err_code_d;

  logic          strobe;
  logic          buf_we;
  logic [7:0]    buf_rd;
  logic          abort_vld;
  logic [2:0]    abort_code;

  // A held-high receiver level yields a single strobe on its rising edge
  assign rx_prev_d = bus.rx_received;
  assign strobe    = bus.rx_received & ~rx_prev_q;

  uart_cmd_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (buf_we),
    .wr_idx (idx_q[AW-1:0]),
    .wr_dat (bus.rx_data),
    .rd_idx (idx_q[AW-1:0]),
    .rd_dat (buf_rd)
  );

  // Frame parser: next state, running checksum, timeout and registered outputs
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    tmo_d       = tmo_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;
    abort_vld   = 1'b0;
    abort_code  = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        chk_d = '0;
        if (strobe && bus.rx_data == SYNC_BYTE) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (strobe) begin
          if (bus.rx_data[7:4] != 4'd0) begin
            abort_vld  = 1'b1;
            abort_code = ERR_BAD_ADDR;
          end else begin
            base_d  = bus.rx_data[3:0];
            chk_d   = chk_q ^ bus.rx_data;
            state_d = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        if (strobe) begin
          if (bus.rx_data == 8'd0 || bus.rx_data > 8'(MAX_LEN)) begin
            abort_vld  = 1'b1;
            abort_code = ERR_BAD_LEN;
          end else begin
            len_d   = IW'(bus.rx_data);
            chk_d   = chk_q ^ bus.rx_data;
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (strobe) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ bus.rx_data;
          if (idx_q == len_q - IW'(1)) begin
            idx_d   = '0;
            state_d = ST_CHK;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_CHK: begin
        if (strobe) begin
          if (bus.rx_data != chk_q) begin
            abort_vld  = 1'b1;
            abort_code = ERR_BAD_CHK;
          end else begin
            idx_d   = '0;
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        // idx walks 0..LEN-1 issuing writes; reaching LEN means all writes are out
        if (idx_q == len_q) begin
          frame_ok_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + 4'(idx_q);
          wr_data_d = buf_rd;
          idx_d     = idx_q + IW'(1);
        end
        // A byte here cannot be stored; flag it but let the commit finish
        if (strobe) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Inter-byte timeout only runs while a frame is being received
    if (state_q == ST_ADDR || state_q == ST_LEN || state_q == ST_DATA || state_q == ST_CHK) begin
      if (strobe) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        abort_vld  = 1'b1;
        abort_code = ERR_TIMEOUT;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end

    if (abort_vld) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      err_code_d  = abort_code;
      idx_d       = '0;
      chk_d       = '0;
      tmo_d       = '0;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rx_prev_q   <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      rx_prev_q   <= rx_prev_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed testbench for uart_cmd_ctrl.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_cmd_ctrl;

  logic clk;
  logic rst_n;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl #(
    .TIMEOUT_CYCLES (2048),
    .MAX_LEN        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  // Activity monitor, sampled on the falling edge
  int         cyc      = 0;
  int         wn       = 0;
  logic [3:0] wa [64];
  logic [7:0] wd [64];
  int         wcyc [64];
  int         okn      = 0;
  int         ok_cyc   = 0;
  logic       ok_busy  = 1'b0;
  int         errn     = 0;
  int         idle_bad = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.wr_en === 1'b1) begin
      if (wn < 64) begin
        wa[wn]   = bus.wr_addr;
        wd[wn]   = bus.wr_data;
        wcyc[wn] = cyc;
      end
      wn = wn + 1;
    end else if (bus.wr_addr !== 4'd0 || bus.wr_data !== 8'd0) begin
      idle_bad = idle_bad + 1;
    end
    if (bus.frame_ok === 1'b1) begin
      okn     = okn + 1;
      ok_cyc  = cyc;
      ok_busy = bus.busy;
    end
    if (bus.frame_err === 1'b1) begin
      errn = errn + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    bus.rx_data     = b;
    bus.rx_received = 1'b1;
    repeat (hold) @(negedge clk);
    bus.rx_received = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  int w0, ok0, e0, k;

  initial begin
    rst_n           = 1'b0;
    bus.rx_received = 1'b0;
    bus.rx_data     = 8'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_wr_en",     {31'd0, bus.wr_en},     32'd0);
    check("rst_wr_addr",   {28'd0, bus.wr_addr},   32'd0);
    check("rst_wr_data",   {24'd0, bus.wr_data},   32'd0);
    check("rst_frame_ok",  {31'd0, bus.frame_ok},  32'd0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("rst_err_code",  {29'd0, bus.err_code},  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Stray byte in IDLE is ignored
    e0 = errn;
    send_byte(8'h3C, 1);
    check("idle_stray_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_stray_err",  errn - e0, 32'd0);

    // A5 03 02 11 22 32 : writes (3,11) (4,22) then frame_ok
    w0 = wn; ok0 = okn; e0 = errn;
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h02, 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h32, 1);
    wait_idle("f1_idle");
    check("f1_nwr",     wn - w0, 32'd2);
    check("f1_a0",      {28'd0, wa[w0]},   32'h3);
    check("f1_d0",      {24'd0, wd[w0]},   32'h11);
    check("f1_a1",      {28'd0, wa[w0+1]}, 32'h4);
    check("f1_d1",      {24'd0, wd[w0+1]}, 32'h22);
    check("f1_contig",  wcyc[w0+1] - wcyc[w0], 32'd1);
    check("f1_ok_n",    okn - ok0, 32'd1);
    check("f1_ok_time", ok_cyc - wcyc[w0+1], 32'd1);
    check("f1_ok_idle", {31'd0, ok_busy}, 32'd0);
    check("f1_no_err",  errn - e0, 32'd0);

    // A5 0E 03 AA BB CC D0 : address wraps E, F, 0
    w0 = wn; ok0 = okn;
    send_byte(8'hA5, 1); send_byte(8'h0E, 1); send_byte(8'h03, 1);
    send_byte(8'hAA, 1); send_byte(8'hBB, 1); send_byte(8'hCC, 1);
    send_byte(8'hD0, 1);
    wait_idle("f2_idle");
    check("f2_nwr", wn - w0, 32'd3);
    check("f2_a0",  {28'd0, wa[w0]},   32'hE);
    check("f2_a1",  {28'd0, wa[w0+1]}, 32'hF);
    check("f2_a2",  {28'd0, wa[w0+2]}, 32'h0);
    check("f2_d2",  {24'd0, wd[w0+2]}, 32'hCC);
    check("f2_ok",  okn - ok0, 32'd1);

    // A5 01 01 55 00 : bad checksum
    w0 = wn; ok0 = okn; e0 = errn;
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h01, 1);
    send_byte(8'h55, 1); send_byte(8'h00, 1);
    wait_idle("f3_idle");
    check("f3_err_n",  errn - e0, 32'd1);
    check("f3_code",   {29'd0, bus.err_code}, 32'd3);
    check("f3_no_wr",  wn - w0, 32'd0);
    check("f3_no_ok",  okn - ok0, 32'd0);

    // A5 10 : bad address
    w0 = wn; e0 = errn;
    send_byte(8'hA5, 1); send_byte(8'h10, 1);
    wait_idle("f4_idle");
    check("f4_code",  {29'd0, bus.err_code}, 32'd1);
    check("f4_err_n", errn - e0, 32'd1);

    // A5 00 09 : bad length
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h09, 1);
    wait_idle("f5_idle");
    check("f5_code",  {29'd0, bus.err_code}, 32'd2);
    check("f5_no_wr", wn - w0, 32'd0);

    // A5 02 then silence : timeout
    w0 = wn; e0 = errn;
    send_byte(8'hA5, 1); send_byte(8'h02, 1);
    k = 0;
    while (errn == e0 && k < 2300) begin
      @(negedge clk);
      k++;
    end
    check("tmo_fired",  {31'd0, (errn != e0)}, 32'd1);
    check("tmo_window", {31'd0, (k >= 2030 && k <= 2060)}, 32'd1);
    repeat (2) @(negedge clk);
    check("tmo_code",   {29'd0, bus.err_code}, 32'd4);
    check("tmo_idle",   {31'd0, bus.busy}, 32'd0);
    check("tmo_no_wr",  wn - w0, 32'd0);

    // Recovery frame A5 05 01 7E 7A
    w0 = wn; ok0 = okn;
    send_byte(8'hA5, 1); send_byte(8'h05, 1); send_byte(8'h01, 1);
    send_byte(8'h7E, 1); send_byte(8'h7A, 1);
    wait_idle("rec_idle");
    check("rec_nwr", wn - w0, 32'd1);
    check("rec_a0",  {28'd0, wa[w0]}, 32'h5);
    check("rec_d0",  {24'd0, wd[w0]}, 32'h7E);
    check("rec_ok",  okn - ok0, 32'd1);

    // Long-held level, A5 as payload: A5 07 02 A5 3C 9C
    w0 = wn; ok0 = okn; e0 = errn;
    send_byte(8'hA5, 32); send_byte(8'h07, 32); send_byte(8'h02, 32);
    send_byte(8'hA5, 32); send_byte(8'h3C, 32); send_byte(8'h9C, 32);
    wait_idle("hold_idle");
    check("hold_nwr", wn - w0, 32'd2);
    check("hold_a0",  {28'd0, wa[w0]},   32'h7);
    check("hold_d0",  {24'd0, wd[w0]},   32'hA5);
    check("hold_a1",  {28'd0, wa[w0+1]}, 32'h8);
    check("hold_d1",  {24'd0, wd[w0+1]}, 32'h3C);
    check("hold_err", errn - e0, 32'd0);
    check("hold_ok",  okn - ok0, 32'd1);

    // Overrun: A5 00 04 01 02 03 04 00, extra byte during COMMIT
    w0 = wn; ok0 = okn; e0 = errn;
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h04, 1);
    send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1);
    send_byte(8'h04, 1);
    @(negedge clk);
    bus.rx_data = 8'h00; bus.rx_received = 1'b1;
    @(negedge clk);
    bus.rx_received = 1'b0;
    @(negedge clk);
    bus.rx_data = 8'h77; bus.rx_received = 1'b1;
    @(negedge clk);
    bus.rx_received = 1'b0;
    wait_idle("ovr_idle");
    check("ovr_code",  {29'd0, bus.err_code}, 32'd5);
    check("ovr_err_n", errn - e0, 32'd1);
    check("ovr_nwr",   wn - w0, 32'd4);
    check("ovr_a3",    {28'd0, wa[w0+3]}, 32'h3);
    check("ovr_d3",    {24'd0, wd[w0+3]}, 32'h04);
    check("ovr_ok",    okn - ok0, 32'd1);

    // Reset during COMMIT: A5 00 08 01..08 00
    w0 = wn;
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h08, 1);
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), 1);
    end
    @(negedge clk);
    bus.rx_data = 8'h00; bus.rx_received = 1'b1;
    @(negedge clk);
    bus.rx_received = 1'b0;
    repeat (4) @(negedge clk);
    check("rmc_pre_wr", {31'd0, bus.wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmc_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("rmc_busy",  {31'd0, bus.busy},  32'd0);
    check("rmc_code",  {29'd0, bus.err_code}, 32'd0);
    ok0 = wn;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rmc_partial",   {31'd0, ((ok0 - w0) > 0 && (ok0 - w0) < 8)}, 32'd1);
    check("rmc_no_more",   wn - ok0, 32'd0);
    check("idle_zero_bus", idle_bad, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
